// File: rtl/fcfs_req_queue.sv
// First-come-first-served request queue feeding the bus arbiter: detects falling
// edges on active-low request lines and presents the oldest requester as head.
module fcfs_req_queue #(
  parameter int N_MASTERS = 8,
  parameter int ID_W      = 3,
  parameter int CNT_W     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_MASTERS-1:0] req,
  input  logic                 pop,
  output logic                 head_valid,
  output logic [ID_W-1:0]      head_id,
  output logic [CNT_W-1:0]     count,
  output logic [N_MASTERS-1:0] pending,
  output logic                 pop_err
);

  logic [N_MASTERS-1:0] req_q_r;
  logic [ID_W-1:0]      mem_r [N_MASTERS];
  logic [ID_W-1:0]      rd_ptr_r;
  logic [ID_W-1:0]      wr_ptr_r;

  logic [N_MASTERS-1:0] fall_s;
  logic                 do_pop_s;
  logic [N_MASTERS-1:0] pend_s;
  logic [ID_W-1:0]      mem_s [N_MASTERS];
  logic [ID_W-1:0]      rd_s;
  logic [ID_W-1:0]      wr_s;
  logic [CNT_W-1:0]     cnt_s;
  logic                 hv_s;
  logic [ID_W-1:0]      hid_s;
  logic                 err_s;

  // Pointer advance modulo N_MASTERS, so non-power-of-two depths also wrap correctly.
  function automatic logic [ID_W-1:0] ptr_inc(input logic [ID_W-1:0] p);
    if (p == ID_W'(N_MASTERS - 1)) begin
      return '0;
    end else begin
      return p + ID_W'(1);
    end
  endfunction

  // Next-state computation: the pop is applied first, then appends in ascending index order.
  always_comb begin
    fall_s   = req_q_r & ~req;
    do_pop_s = pop & head_valid;
    err_s    = pop & ~head_valid;
    pend_s   = pending;
    mem_s    = mem_r;
    rd_s     = rd_ptr_r;
    wr_s     = wr_ptr_r;
    cnt_s    = count;
    hv_s     = 1'b0;
    hid_s    = '0;

    if (do_pop_s) begin
      pend_s[head_id] = 1'b0;
      rd_s            = ptr_inc(rd_ptr_r);
      cnt_s           = count - CNT_W'(1);
    end else begin
      rd_s = rd_ptr_r;
    end

    // A master freed by this cycle's pop may re-append here, landing at the tail.
    for (int i = 0; i < N_MASTERS; i++) begin
      if (fall_s[i] && !pend_s[i]) begin
        mem_s[wr_s] = ID_W'(i);
        wr_s        = ptr_inc(wr_s);
        pend_s[i]   = 1'b1;
        cnt_s       = cnt_s + CNT_W'(1);
      end else begin
        pend_s[i] = pend_s[i];
      end
    end

    if (cnt_s != '0) begin
      hv_s  = 1'b1;
      hid_s = mem_s[rd_s];
    end else begin
      hv_s  = 1'b0;
      hid_s = '0;
    end
  end

  // State and registered outputs; reset discards every entry and idles the request sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q_r    <= '1;
      rd_ptr_r   <= '0;
      wr_ptr_r   <= '0;
      for (int i = 0; i < N_MASTERS; i++) begin
        mem_r[i] <= '0;
      end
      head_valid <= 1'b0;
      head_id    <= '0;
      count      <= '0;
      pending    <= '0;
      pop_err    <= 1'b0;
    end else begin
      req_q_r    <= req;
      rd_ptr_r   <= rd_s;
      wr_ptr_r   <= wr_s;
      mem_r      <= mem_s;
      head_valid <= hv_s;
      head_id    <= hid_s;
      count      <= cnt_s;
      pending    <= pend_s;
      pop_err    <= err_s;
    end
  end

endmodule

// File: tb/tb_fcfs_req_queue.sv
// Scoreboard bench for fcfs_req_queue: a queue-based reference model predicts the
// outputs after every edge; a separate monitor compares them against the DUT.
module tb_fcfs_req_queue;

  typedef struct packed {
    logic       hv;
    logic [2:0] hid;
    logic [3:0] cnt;
    logic [7:0] pend;
    logic       err;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = 8'hFF;
  logic       pop = 1'b0;
  logic       head_valid;
  logic [2:0] head_id;
  logic [3:0] count;
  logic [7:0] pending;
  logic       pop_err;

  int n_vec = 0;
  int n_bad = 0;

  exp_t exp_q[$];
  int   model_q[$];
  logic [7:0] model_prev = 8'hFF;

  fcfs_req_queue #(.N_MASTERS(8), .ID_W(3), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .req(req), .pop(pop),
    .head_valid(head_valid), .head_id(head_id), .count(count),
    .pending(pending), .pop_err(pop_err)
  );

  always #5 clk = ~clk;

  function automatic bit in_model(input int id);
    foreach (model_q[k]) if (model_q[k] == id) return 1'b1;
    return 1'b0;
  endfunction

  // Reference model: arrival-ordered list of IDs; outputs derived from the list itself.
  task automatic model_step(input logic r, input logic [7:0] rq, input logic p);
    exp_t e;
    logic [7:0] f;
    e = '0;
    if (r) begin
      model_q.delete();
      model_prev = 8'hFF;
    end else begin
      f = model_prev & ~rq;
      e.err = p && (model_q.size() == 0);
      if (p && model_q.size() > 0) void'(model_q.pop_front());
      for (int i = 0; i < 8; i++)
        if (f[i] && !in_model(i)) model_q.push_back(i);
      model_prev = rq;
      e.cnt = 4'(model_q.size());
      e.hv  = (model_q.size() > 0);
      e.hid = e.hv ? 3'(model_q[0]) : 3'd0;
      foreach (model_q[k]) e.pend[model_q[k]] = 1'b1;
    end
    exp_q.push_back(e);
  endtask

  task automatic cyc(input logic r, input logic [7:0] rq, input logic p);
    @(negedge clk);
    rst = r;
    req = rq;
    pop = p;
    model_step(r, rq, p);
  endtask

  // Monitor: one expected record per edge, checked just after the edge.
  initial begin
    exp_t e, a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {head_valid, head_id, count, pending, pop_err};
        n_vec++;
        if (a !== e) begin
          n_bad++;
          $display("FAIL outputs t=%0t got hv=%b id=%0d cnt=%0d pend=%h err=%b want hv=%b id=%0d cnt=%0d pend=%h err=%b",
                   $time, a.hv, a.hid, a.cnt, a.pend, a.err, e.hv, e.hid, e.cnt, e.pend, e.err);
        end
      end
    end
  end

  initial begin
    logic [7:0] rv;
    // Single request after reset
    cyc(1'b1, 8'hFF, 1'b0);
    cyc(1'b0, 8'hFF, 1'b0);
    cyc(1'b0, 8'hF7, 1'b0);
    cyc(1'b0, 8'hF7, 1'b0);
    cyc(1'b0, 8'hF7, 1'b1);
    cyc(1'b0, 8'hFF, 1'b0);
    // Arrival order 5,1,{2,6}, then drained
    cyc(1'b0, 8'hDF, 1'b0);
    cyc(1'b0, 8'hDF, 1'b0);
    cyc(1'b0, 8'hDD, 1'b0);
    cyc(1'b0, 8'hDD, 1'b0);
    cyc(1'b0, 8'h99, 1'b0);
    cyc(1'b0, 8'h99, 1'b0);
    for (int k = 0; k < 5; k++) cyc(1'b0, 8'hFF, 1'b1);
    cyc(1'b0, 8'hFF, 1'b0);
    // Duplicate fall while queued
    cyc(1'b0, 8'hEF, 1'b0);
    cyc(1'b0, 8'hFF, 1'b0);
    cyc(1'b0, 8'hEF, 1'b0);
    cyc(1'b0, 8'hEF, 1'b1);
    cyc(1'b0, 8'hFF, 1'b0);
    // Pop and re-fall of the same master in one cycle
    cyc(1'b0, 8'h7F, 1'b0);
    cyc(1'b0, 8'hFF, 1'b0);
    cyc(1'b0, 8'h7F, 1'b1);
    cyc(1'b0, 8'hFF, 1'b1);
    // Pop on empty
    cyc(1'b0, 8'hFF, 1'b1);
    cyc(1'b0, 8'hFF, 1'b0);
    // All eight fall together, pops interleaved with new falls (wrap-around)
    cyc(1'b0, 8'h00, 1'b0);
    cyc(1'b0, 8'hFF, 1'b1);
    cyc(1'b0, 8'hFF, 1'b1);
    cyc(1'b0, 8'hFB, 1'b1);
    cyc(1'b0, 8'hFF, 1'b1);
    cyc(1'b0, 8'hFE, 1'b1);
    cyc(1'b0, 8'hFF, 1'b1);
    cyc(1'b0, 8'h7F, 1'b1);
    cyc(1'b0, 8'hFF, 1'b1);
    for (int k = 0; k < 4; k++) cyc(1'b0, 8'hFF, 1'b1);
    // Reset mid-operation with pop and a fall on master 0
    cyc(1'b0, 8'hF0, 1'b0);
    cyc(1'b0, 8'hF1, 1'b0);
    cyc(1'b1, 8'hF0, 1'b1);
    cyc(1'b0, 8'hFE, 1'b0);
    cyc(1'b0, 8'hFF, 1'b1);
    // Randomized traffic
    rv = 8'hFF;
    for (int k = 0; k < 3000; k++) begin
      rv = rv ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      cyc(($urandom_range(0, 199) == 0), rv, ($urandom_range(0, 99) < 40));
    end
    cyc(1'b0, 8'hFF, 1'b0);
    @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain got %0d pending records want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
